// File: rtl/skp_compensation_ctrl.sv
// Read-side SKP compensation for the elastic buffer: watches SKP ordered sets at the
// buffer head and inserts or drops one SKP per set to re-centre occupancy.
module skp_compensation_ctrl #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter logic [7:0] SKP_SYMBOL = 8'h1C,
  parameter int         MIN_SKP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] head_data,
  input  logic       head_k,
  input  logic       buffer_empty,
  input  logic       add_req,
  input  logic       delete_req,
  output logic       read_en,
  output logic [7:0] data_out,
  output logic       data_k_out,
  output logic       data_valid,
  output logic       skp_added,
  output logic       skp_removed
);

  typedef enum logic [1:0] {PASS, OS_SKP, DONE_OS} state_t;
  typedef enum logic [1:0] {ACT_NONE, ACT_ADD, ACT_DEL} action_t;

  localparam logic [2:0] MIN_SKP_C = 3'(MIN_SKP);

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  logic       add_s1, add_s, del_s1, del_s;
  state_t     state, state_nx;
  action_t    action, action_nx;
  logic [2:0] skp_cnt, skp_cnt_nx;
  logic       is_com, is_skp, take_pass;
  logic [7:0] data_p0;
  logic       k_p0, vld_p0, added_p0, removed_p0;

  assign is_com = head_k && (head_data == COM_SYMBOL);
  assign is_skp = head_k && (head_data == SKP_SYMBOL);

  always_ff @(posedge clk) begin
    if (rst) begin
      add_s1 <= 1'b0;
      add_s  <= 1'b0;
      del_s1 <= 1'b0;
      del_s  <= 1'b0;
    end else begin
      add_s1 <= add_req;
      add_s  <= add_s1;
      del_s1 <= delete_req;
      del_s  <= del_s1;
    end
  end

  // p0: decode the head symbol and decide read / forward / insert / drop
  always_comb begin
    read_en    = 1'b0;
    data_p0    = head_data;
    k_p0       = head_k;
    vld_p0     = 1'b0;
    added_p0   = 1'b0;
    removed_p0 = 1'b0;
    state_nx   = state;
    action_nx  = action;
    skp_cnt_nx = skp_cnt;
    take_pass  = 1'b0;
    if (!rst && !buffer_empty) begin
      case (state)
        PASS: take_pass = 1'b1;
        OS_SKP: begin
          if (!is_skp) begin
            take_pass = 1'b1;
          end else if (action == ACT_ADD && skp_cnt == 3'd0) begin
            data_p0   = SKP_SYMBOL;
            k_p0      = 1'b1;
            vld_p0    = 1'b1;
            added_p0  = 1'b1;
            action_nx = ACT_NONE;
            state_nx  = DONE_OS;
          end else if (action == ACT_DEL && skp_cnt >= MIN_SKP_C) begin
            read_en    = 1'b1;
            removed_p0 = 1'b1;
            action_nx  = ACT_NONE;
            state_nx   = DONE_OS;
          end else begin
            read_en    = 1'b1;
            vld_p0     = 1'b1;
            skp_cnt_nx = sat_inc(skp_cnt);
          end
        end
        DONE_OS: begin
          if (is_skp) begin
            read_en = 1'b1;
            vld_p0  = 1'b1;
          end else begin
            take_pass = 1'b1;
          end
        end
        default: take_pass = 1'b1;
      endcase
      // A non-SKP ending an ordered set is handled exactly like PASS, in the same cycle
      if (take_pass) begin
        read_en = 1'b1;
        vld_p0  = 1'b1;
        if (is_com) begin
          action_nx  = del_s ? ACT_DEL : (add_s ? ACT_ADD : ACT_NONE);
          skp_cnt_nx = 3'd0;
          state_nx   = OS_SKP;
        end else begin
          action_nx  = ACT_NONE;
          state_nx   = PASS;
        end
      end
    end
  end

  // p1: registered outputs and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PASS;
      action      <= ACT_NONE;
      skp_cnt     <= 3'd0;
      data_out    <= 8'd0;
      data_k_out  <= 1'b0;
      data_valid  <= 1'b0;
      skp_added   <= 1'b0;
      skp_removed <= 1'b0;
    end else begin
      state       <= state_nx;
      action      <= action_nx;
      skp_cnt     <= skp_cnt_nx;
      data_valid  <= vld_p0;
      skp_added   <= added_p0;
      skp_removed <= removed_p0;
      if (vld_p0) begin
        data_out   <= data_p0;
        data_k_out <= k_p0;
      end
    end
  end

endmodule

// File: tb/tb_skp_compensation_ctrl.sv
// Scoreboard bench for skp_compensation_ctrl: a queue models the elastic buffer head,
// expected output symbols are queued at stimulus time and popped by a monitor.
module tb_skp_compensation_ctrl;

  localparam logic [8:0] COM = {1'b1, 8'hBC};
  localparam logic [8:0] SKP = {1'b1, 8'h1C};
  localparam logic [8:0] D0  = {1'b0, 8'h4A};
  localparam logic [8:0] D1  = {1'b0, 8'hB5};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] head_data = 8'd0;
  logic       head_k = 1'b0;
  logic       buffer_empty = 1'b1;
  logic       add_req = 1'b0;
  logic       delete_req = 1'b0;
  logic       read_en;
  logic [7:0] data_out;
  logic       data_k_out;
  logic       data_valid;
  logic       skp_added;
  logic       skp_removed;

  logic [8:0] buf_q[$];
  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int added_cnt, removed_cnt, stall_cnt;

  always #5 clk = ~clk;

  skp_compensation_ctrl dut (
    .clk(clk), .rst(rst), .head_data(head_data), .head_k(head_k),
    .buffer_empty(buffer_empty), .add_req(add_req), .delete_req(delete_req),
    .read_en(read_en), .data_out(data_out), .data_k_out(data_k_out),
    .data_valid(data_valid), .skp_added(skp_added), .skp_removed(skp_removed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_head();
    buffer_empty = (buf_q.size() == 0);
    if (buf_q.size() != 0) {head_k, head_data} = buf_q[0];
    else {head_k, head_data} = 9'd0;
  endtask

  task automatic load(input logic [8:0] s);
    buf_q.push_back(s);
    exp_q.push_back(s);
    update_head();
  endtask

  task automatic cycle();
    logic rd;
    @(negedge clk);
    rd = read_en;
    if (buffer_empty) chk("read_en_while_empty", 32'(rd), 32'd0);
    if (!rd && !buffer_empty && !rst) stall_cnt++;
    @(posedge clk);
    #1;
    if (rd && buf_q.size() != 0) void'(buf_q.pop_front());
    update_head();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((buf_q.size() != 0 || exp_q.size() != 0) && n < 60) begin
      cycle();
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) cycle();
  endtask

  task automatic start_test(input logic a, input logic d);
    add_req = a;
    delete_req = d;
    added_cnt = 0;
    removed_cnt = 0;
    stall_cnt = 0;
    repeat (3) cycle();
  endtask

  task automatic end_test(input string name, input int exp_add, input int exp_rem, input int exp_stall);
    chk({name, "_skp_added"}, 32'(added_cnt), 32'(exp_add));
    chk({name, "_skp_removed"}, 32'(removed_cnt), 32'(exp_rem));
    chk({name, "_stalls"}, 32'(stall_cnt), 32'(exp_stall));
    add_req = 1'b0;
    delete_req = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (skp_added) added_cnt++;
        if (skp_removed) removed_cnt++;
        if (data_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", {23'd0, data_k_out, data_out}, 32'h1FF);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("stream_symbol", {23'd0, data_k_out, data_out}, {23'd0, e});
          end
        end
      end
    join_none

    // Reset with a valid COM at the head: nothing may be read or forwarded
    buffer_empty = 1'b0;
    {head_k, head_data} = COM;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_en", 32'(read_en), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", {23'd0, data_k_out, data_out}, 32'd0);
    chk("rst_pulses", {30'd0, skp_added, skp_removed}, 32'd0);
    rst = 1'b0;
    update_head();

    // No requests: stream passes unchanged
    start_test(1'b0, 1'b0);
    load(D0); load(COM); load(SKP); load(SKP); load(SKP); load(D1);
    drain("pass");
    end_test("pass", 0, 0, 0);

    // Delete: second SKP dropped
    start_test(1'b0, 1'b1);
    load(COM); load(SKP); load(SKP); load(SKP); load(D1);
    void'(exp_q.pop_back()); void'(exp_q.pop_back()); exp_q.push_back(D1);
    drain("del");
    end_test("del", 0, 1, 0);

    // Add: one extra SKP, one stall cycle
    start_test(1'b1, 1'b0);
    load(COM); load(SKP); load(SKP); load(SKP); load(D1);
    void'(exp_q.pop_back()); exp_q.push_back(SKP); exp_q.push_back(D1);
    drain("add");
    end_test("add", 1, 0, 1);

    // Delete with only one SKP: MIN_SKP protects it
    start_test(1'b0, 1'b1);
    load(COM); load(SKP); load(D1);
    drain("del_min");
    end_test("del_min", 0, 0, 0);

    // Both requests: delete wins
    start_test(1'b1, 1'b1);
    load(COM); load(SKP); load(SKP); load(D1);
    void'(exp_q.pop_back()); void'(exp_q.pop_back()); exp_q.push_back(D1);
    drain("both");
    end_test("both", 0, 1, 0);

    // Add with an empty gap between two SKPs
    start_test(1'b1, 1'b0);
    load(COM); load(SKP);
    exp_q.push_back(SKP);
    drain("gap_a");
    chk("gap_empty", 32'(buffer_empty), 32'd1);
    repeat (1) cycle();
    load(SKP); load(D1);
    drain("gap_b");
    end_test("gap", 1, 0, 1);

    // Reset right after COM with delete pending
    start_test(1'b0, 1'b1);
    load(COM); load(SKP); load(SKP); load(SKP); load(D1);
    cycle();
    rst = 1'b1;
    cycle();
    chk("mid_rst_data_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_data_out", {23'd0, data_k_out, data_out}, 32'd0);
    chk("mid_rst_pulses", {30'd0, skp_added, skp_removed}, 32'd0);
    rst = 1'b0;
    drain("rst");
    end_test("rst", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skp_compensation_ctrl.md
Name: skp_compensation_ctrl

Overview:
- Read-side consumer of the elastic buffer's fill-level requests (`add_req` / `delete_req`).
- Watches the symbol stream leaving the buffer head and drives the buffer read enable.
- Inserts or deletes one SKP symbol per SKP ordered set (COM followed by SKPs) to re-centre buffer occupancy.
- Forwards the compensated 8b/10b-decoded symbol stream to the downstream RX logic.

Parameters:
- COM_SYMBOL, 8'hBC, K28.5 comma code; starts an ordered set when `head_k` = 1.
- SKP_SYMBOL, 8'h1C, K28.0 skip code; counted and compensated when `head_k` = 1.
- MIN_SKP, 1, number of SKPs of the current ordered set that must already have been forwarded before a delete is allowed.

Ports:
- `clk`  input  1  read-domain clock.
- `rst`  input  1  synchronous, active-high reset.
- `head_data`  input  8  symbol at the buffer read pointer.
- `head_k`  input  1  K-flag of `head_data`.
- `buffer_empty`  input  1  buffer has no readable entry.
- `add_req`  input  1  occupancy low, request SKP insertion; not synchronous to `clk`.
- `delete_req`  input  1  occupancy high, request SKP deletion; not synchronous to `clk`.
- `read_en`  output  1  advance the buffer read pointer this cycle (combinational).
- `data_out`  output  8  forwarded symbol.
- `data_k_out`  output  1  K-flag of `data_out`.
- `data_valid`  output  1  `data_out` / `data_k_out` valid.
- `skp_added`  output  1  one-cycle pulse, a SKP was inserted.
- `skp_removed`  output  1  one-cycle pulse, a SKP was dropped.

Behaviour:
- Clock and reset:
  - One clock; `rst` is synchronous, active-high.
  - Reset values: `data_out` = 0, `data_k_out` = 0, `data_valid` = 0, `skp_added` = 0, `skp_removed` = 0, state = PASS, `skp_cnt` = 0, action = NONE, sync flops = 0.
  - `read_en` is 0 while `rst` = 1.
- Request synchronisation:
  - `add_req` and `delete_req` each pass through a 2-flop synchroniser, giving `add_s` and `del_s`.
- Output timing:
  - All outputs except `read_en` are registered.
  - A head symbol consumed in cycle N appears on `data_out` in cycle N+1.
- Symbol decode: `is_com` = `head_k` & (`head_data` == COM_SYMBOL); `is_skp` = `head_k` & (`head_data` == SKP_SYMBOL).
- Empty buffer: if `buffer_empty`, then `read_en` = 0, `data_valid` = 0 next cycle, and state, count and action are held.
- State PASS:
  - `read_en` = 1; forward head with `data_valid` = 1.
  - On `is_com`: latch action = DEL if `del_s`, else ADD if `add_s`, else NONE; clear `skp_cnt`; go to OS_SKP.
  - If both requests are high, DEL wins.
- State OS_SKP, head `is_skp`, action ADD and `skp_cnt` == 0:
  - `read_en` = 0; output SKP_SYMBOL with K = 1 and `data_valid` = 1; pulse `skp_added`.
  - Set action = NONE; go to DONE_OS.
  - The same head SKP is then read and forwarded normally next cycle, so exactly one extra SKP appears.
- State OS_SKP, head `is_skp`, action DEL and `skp_cnt` >= MIN_SKP:
  - `read_en` = 1; `data_valid` = 0 next cycle (symbol dropped); pulse `skp_removed`.
  - Go to DONE_OS.
- State OS_SKP, head `is_skp`, otherwise: forward it, increment `skp_cnt` (saturates at 7).
- State OS_SKP, head not `is_skp`:
  - Ordered set ended before the action was taken; the action is discarded with no pulse.
  - Process the head exactly as PASS does in the same cycle: forward it, and a COM starts a new ordered set.
- State DONE_OS:
  - Forward SKPs unchanged.
  - On the first non-SKP symbol, behave as PASS in the same cycle.
- Limits per ordered set:
  - At most one add or delete.
  - A delete never leaves fewer than MIN_SKP SKPs.
  - An insert never touches non-SKP symbols.
- Requests changing mid-ordered-set have no effect; the action is latched only at COM.
- Reset mid-ordered-set: next cycle state = PASS, outputs cleared, and no pending insert or delete survives.

Test Plan:
- Both requests low, stream D0 COM SKP SKP SKP D1 → identical stream out, one-cycle latency, no pulses.
- `delete_req` = 1 (held ≥ 3 cycles), COM SKP SKP SKP D1 → out COM SKP SKP D1; one bubble cycle (`data_valid` = 0) after the first SKP; `skp_removed` pulses once.
- `add_req` = 1, COM SKP SKP SKP D1 → out COM SKP SKP SKP SKP D1; `read_en` = 0 for exactly one cycle; `skp_added` pulses once.
- `delete_req` = 1, COM SKP D1 (MIN_SKP = 1) → out COM SKP D1 unchanged, no pulse.
- `buffer_empty` = 1 for 3 cycles between two SKPs with `add_req` = 1 → `read_en` = 0 and `data_valid` = 0 during the gap; insertion still occurs at the first SKP only.
- `rst` asserted in the cycle after COM with `delete_req` = 1 → all outputs 0 next cycle; the following SKPs pass unmodified.
